// File: rtl/ram_wb_port.sv
// ram_wb_port: Wishbone-classic slave driving a single-port synchronous RAM macro
// (EN, WE[3:0], Di, Do, A; one-cycle read latency).
// Writes are acknowledged one cycle after the request and take two cycles per transfer.
// Reads are acknowledged two cycles after the request and take three cycles per transfer.
// Optional feature macro: RAM_INIT_EN. When it is defined, the RAM is filled with
// INIT_VAL after reset, one word per cycle, and busy_o is high while this runs.
module ram_wb_port #(
    parameter int          AW       = 12,
    parameter logic [31:0] INIT_VAL = 32'h0000_0000
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic          wb_we_i,
    input  logic [3:0]    wb_sel_i,
    input  logic [AW+1:0] wb_adr_i,
    input  logic [31:0]   wb_dat_i,
    output logic [31:0]   wb_dat_o,
    output logic          wb_ack_o,
    output logic          busy_o,
    output logic          ram_en_o,
    output logic [3:0]    ram_we_o,
    output logic [31:0]   ram_di_o,
    output logic [AW-1:0] ram_a_o,
    input  logic [31:0]   ram_do_i
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ACK,
        RD_WAIT,
        RD_ACK
`ifdef RAM_INIT_EN
        , INIT
`endif
    } state_t;

`ifdef RAM_INIT_EN
    localparam state_t RESET_STATE = INIT;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t      state_q, state_d;
    logic [31:0] dat_q, dat_d;
    logic        abort_q, abort_d;
    logic        req;

    // The byte-offset bits of the address carry no information for a word RAM.
    logic [1:0]  unused_adr_lsb;
    assign unused_adr_lsb = wb_adr_i[1:0];

`ifdef RAM_INIT_EN
    logic [AW-1:0] cnt_q, cnt_d;
`else
    logic [31:0]   unused_init_val;
    assign unused_init_val = INIT_VAL;
`endif

    // A request is only accepted while idle; every other state is busy with a transfer.
    assign req = wb_cyc_i & wb_stb_i & (state_q == IDLE);

    // Next-state logic for the transfer sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = wb_we_i ? WR_ACK : RD_WAIT;
            WR_ACK:  state_d = IDLE;
            RD_WAIT: state_d = RD_ACK;
            RD_ACK:  state_d = IDLE;
`ifdef RAM_INIT_EN
            INIT:    if (cnt_q == '1) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Read data is captured the cycle the RAM presents it; an abort is remembered so
    // that the following ack cycle stays silent even if cyc comes back.
    always_comb begin
        dat_d   = (state_q == RD_WAIT) ? ram_do_i : dat_q;
        abort_d = (state_q == RD_WAIT) & ~wb_cyc_i;
`ifdef RAM_INIT_EN
        cnt_d   = (state_q == INIT) ? cnt_q + 1'b1 : cnt_q;
`endif
    end

    // RAM strobes are combinational from the bus; the init engine overrides them.
    always_comb begin
        ram_en_o = req;
        ram_we_o = (req && wb_we_i) ? wb_sel_i : 4'h0;
        ram_di_o = wb_dat_i;
        ram_a_o  = wb_adr_i[AW+1:2];
`ifdef RAM_INIT_EN
        if (state_q == INIT) begin
            ram_en_o = 1'b1;
            ram_we_o = 4'hF;
            ram_di_o = INIT_VAL;
            ram_a_o  = cnt_q;
        end
`endif
    end

    // State, read-data and abort registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RESET_STATE;
            dat_q   <= 32'h0;
            abort_q <= 1'b0;
`ifdef RAM_INIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            dat_q   <= dat_d;
            abort_q <= abort_d;
`ifdef RAM_INIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Ack is gated by cyc so a master that has left the cycle never sees a late ack.
    assign wb_ack_o = wb_cyc_i & ((state_q == WR_ACK) | ((state_q == RD_ACK) & ~abort_q));
    assign wb_dat_o = dat_q;

`ifdef RAM_INIT_EN
    assign busy_o = (state_q == INIT);
`else
    assign busy_o = 1'b0;
`endif

endmodule

// File: tb/tb_ram_wb_port.sv
// Bench for ram_wb_port: behavioural single-port RAM, directed Wishbone transfers,
// and a queue of expected read data popped at each read acknowledge.
module tb_ram_wb_port;

    localparam int          AW    = 12;
    localparam logic [31:0] IVAL  = 32'hA5A5_A5A5;
`ifdef RAM_INIT_EN
    localparam logic        INIT_ON = 1'b1;
`else
    localparam logic        INIT_ON = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST;
    logic          cyc, stb, we;
    logic [3:0]    sel;
    logic [AW+1:0] adr;
    logic [31:0]   dat_w;
    logic [31:0]   dat_r;
    logic          ack, busy, ram_en;
    logic [3:0]    ram_we;
    logic [31:0]   ram_di, ram_do;
    logic [AW-1:0] ram_a;

    logic [31:0]   mem     [0:(1<<AW)-1];
    logic [31:0]   exp_mem [0:(1<<AW)-1];
    logic [31:0]   sb_q [$];

    int n_assert = 0;
    int n_fail   = 0;

    ram_wb_port #(.AW(AW), .INIT_VAL(IVAL)) dut (
        .CLK(CLK), .RST(RST),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel),
        .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_dat_o(dat_r), .wb_ack_o(ack),
        .busy_o(busy), .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_di_o(ram_di),
        .ram_a_o(ram_a), .ram_do_i(ram_do)
    );

    always #5 CLK = ~CLK;

    // Behavioural DFFRAM-style macro: byte-enabled write, registered read.
    always @(posedge CLK) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
            ram_do <= mem[ram_a];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wb_write(input logic [AW+1:0] a, input logic [31:0] d, input logic [3:0] s);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_w = d; sel = s;
        @(negedge CLK);
        check("wr_en", 32'(ram_en), 32'd1);
        check("wr_we", 32'(ram_we), 32'(s));
        check("wr_addr", 32'(ram_a), 32'(a[AW+1:2]));
        check("wr_ack_early", 32'(ack), 32'd0);
        for (int b = 0; b < 4; b++)
            if (s[b]) exp_mem[a[AW+1:2]][8*b +: 8] = d[8*b +: 8];
        step();
        @(negedge CLK);
        check("wr_ack", 32'(ack), 32'd1);
        check("wr_en_in_ack", 32'(ram_en), 32'd0);
        step();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        check({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) check(tag, dat_r, sb_q.pop_front());
    endtask

    task automatic wb_read(input logic [AW+1:0] a, input logic hold);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'h0;
        sb_q.push_back(exp_mem[a[AW+1:2]]);
        @(negedge CLK);
        check("rd_en", 32'(ram_en), 32'd1);
        check("rd_we", 32'(ram_we), 32'd0);
        check("rd_ack_n", 32'(ack), 32'd0);
        step();
        @(negedge CLK);
        check("rd_ack_n1", 32'(ack), 32'd0);
        check("rd_en_wait", 32'(ram_en), 32'd0);
        step();
        @(negedge CLK);
        check("rd_ack_n2", 32'(ack), 32'd1);
        check("rd_en_ack", 32'(ram_en), 32'd0);
        pop_check("rd_dat");
        step();
        if (!hold) begin
            cyc = 1'b0; stb = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 5000) begin
            step();
            n++;
        end
        check("wait_idle_bounded", 32'(busy), 32'd0);
    endtask

    initial begin
        int busy_cnt;
        int ack_cnt;
        RST = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        adr = '0; dat_w = 32'h0;
        if (INIT_ON)
            for (int i = 0; i < (1 << AW); i++) exp_mem[i] = IVAL;
        repeat (3) step();

        // Reset state
        @(negedge CLK);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", dat_r, 32'h0);
        check("rst_busy", 32'(busy), 32'(INIT_ON));
        check("rst_en", 32'(ram_en), 32'(INIT_ON));
        step();
        RST = 1'b0;

        // Init engine: busy length and ignored requests
        busy_cnt = 0;
        ack_cnt  = 0;
        if (INIT_ON) begin
            while (busy_cnt < 5000) begin
                if (busy_cnt == 10) begin cyc = 1'b1; stb = 1'b1; we = 1'b0; end
                if (busy_cnt == 100) begin cyc = 1'b0; stb = 1'b0; end
                @(negedge CLK);
                if (ack === 1'b1) ack_cnt++;
                if (busy !== 1'b1) break;
                busy_cnt++;
                step();
            end
            check("init_busy_cycles", 32'(busy_cnt), 32'd4096);
            check("init_no_ack", 32'(ack_cnt), 32'd0);
            step();
            wb_read(14'h0000, 1'b0);
            wb_read(14'h3FFC, 1'b0);
        end else begin
            @(negedge CLK);
            check("busy_tied_low", 32'(busy), 32'd0);
            step();
        end

        // Test 1: write then read back
        wb_write(14'h0010, 32'hDEADBEEF, 4'hF);
        wb_read(14'h0010, 1'b0);

        // Write with no byte lanes: enabled, no write, still acked
        wb_write(14'h0010, 32'h01234567, 4'h0);
        wb_read(14'h0010, 1'b0);

        // Test 2: partial byte write
        wb_write(14'h0020, 32'h11223344, 4'hF);
        wb_write(14'h0020, 32'hAABBCCDD, 4'b0010);
        check("sel_model", exp_mem[8], 32'h1122CC44);
        wb_read(14'h0020, 1'b0);

        // Test 3: back-to-back reads with strobe held
        wb_write(14'h0000, 32'h0000_1111, 4'hF);
        wb_write(14'h0004, 32'h0000_2222, 4'hF);
        wb_write(14'h0008, 32'h0000_3333, 4'hF);
        wb_read(14'h0000, 1'b1);
        wb_read(14'h0004, 1'b1);
        wb_read(14'h0008, 1'b0);

        // Test 4: abort in RD_WAIT, data still captured, no ack
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 14'h0010;
        sb_q.push_back(exp_mem[4]);
        @(negedge CLK);
        check("abort_en", 32'(ram_en), 32'd1);
        step();
        cyc = 1'b0; stb = 1'b0;
        @(negedge CLK);
        check("abort_ack_wait", 32'(ack), 32'd0);
        step();
        cyc = 1'b1;
        @(negedge CLK);
        check("abort_ack_rdack", 32'(ack), 32'd0);
        step();
        cyc = 1'b0;
        @(negedge CLK);
        pop_check("abort_dat");
        step();
        wb_write(14'h0030, 32'hCAFEF00D, 4'hF);
        wb_read(14'h0030, 1'b0);

        // Test 6: reset during RD_WAIT
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 14'h0020;
        @(negedge CLK);
        check("rstmid_en", 32'(ram_en), 32'd1);
        step();
        RST = 1'b1; cyc = 1'b0; stb = 1'b0;
        @(negedge CLK);
        check("rstmid_ack_wait", 32'(ack), 32'd0);
        step();
        RST = 1'b0; cyc = 1'b1;
        @(negedge CLK);
        check("rstmid_ack", 32'(ack), 32'd0);
        check("rstmid_dat", dat_r, 32'h0);
        check("rstmid_busy", 32'(busy), 32'(INIT_ON));
        ack_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge CLK);
            if (ack === 1'b1) ack_cnt++;
        end
        check("rstmid_no_stray_ack", 32'(ack_cnt), 32'd0);
        step();
        cyc = 1'b0;
        wait_idle();
        wb_read(14'h0020, 1'b0);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
